// File: rtl/snax_gemm_wb_streamer.sv
// GEMM write-back streamer: captures one C tile and writes it to TCDM over parallel ports, beat by beat.
// Optional stall counter output is enabled with `define SNAX_GEMM_WB_PERF_EN.
module snax_gemm_wb_streamer #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned TcdmPorts   = 16,
  parameter int unsigned AddrWidth   = 17,
  parameter int unsigned ResultWidth = 2048
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           c_valid_i,
  output logic                           c_ready_o,
  input  logic [ResultWidth-1:0]         c_data_i,
  input  logic [AddrWidth-1:0]           c_base_addr_i,
  output logic [TcdmPorts-1:0]           tcdm_q_valid_o,
  input  logic [TcdmPorts-1:0]           tcdm_q_ready_i,
  output logic [TcdmPorts*AddrWidth-1:0] tcdm_q_addr_o,
  output logic [TcdmPorts*DataWidth-1:0] tcdm_q_data_o,
  output logic                           tcdm_q_write_o,
  output logic [DataWidth/8-1:0]         tcdm_q_strb_o,
  output logic                           busy_o,
`ifdef SNAX_GEMM_WB_PERF_EN
  output logic [31:0]                    stall_cnt_o,
`endif
  output logic                           done_o
);

  localparam int unsigned NumBeats = ResultWidth / (TcdmPorts * DataWidth);
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned StrbW    = DataWidth / 8;
  localparam int unsigned ByteOff  = $clog2(StrbW);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_r, state_s;
  logic [BeatW-1:0]       beat_r, beat_s;
  logic [TcdmPorts-1:0]   mask_r, mask_s;
  logic [TcdmPorts-1:0]   mask_acc_s;
  logic [TcdmPorts-1:0]   q_valid_s;
  logic                   capture_s;
  logic [ResultWidth-1:0] tile_r;
  logic [AddrWidth-1:0]   base_r;

  // State, beat counter and accepted-port mask
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      beat_r  <= '0;
      mask_r  <= '0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      mask_r  <= mask_s;
    end
  end

  // Tile and word-aligned base address capture on accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tile_r <= '0;
      base_r <= '0;
    end else if (capture_s) begin
      tile_r <= c_data_i;
      base_r <= {c_base_addr_i[AddrWidth-1:ByteOff], {ByteOff{1'b0}}};
    end else begin
      tile_r <= tile_r;
      base_r <= base_r;
    end
  end

  // Next-state logic; a beat completes when every port has handshaked, counting this cycle
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    mask_s     = mask_r;
    mask_acc_s = mask_r;
    q_valid_s  = '0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (c_valid_i) begin
          capture_s = 1'b1;
          beat_s    = '0;
          mask_s    = '0;
          state_s   = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        q_valid_s  = ~mask_r;
        mask_acc_s = mask_r | (q_valid_s & tcdm_q_ready_i);
        if (&mask_acc_s) begin
          mask_s = '0;
          if (beat_r == LastBeat) begin
            state_s = DONE;
          end else begin
            beat_s = beat_r + BeatW'(1);
          end
        end else begin
          mask_s = mask_acc_s;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        beat_s  = '0;
        mask_s  = '0;
      end
    endcase
  end

  // Per-port address and data; held constant across a beat since beat_r only moves on completion
  always_comb begin
    int unsigned widx;
    tcdm_q_addr_o = '0;
    tcdm_q_data_o = '0;
    widx          = 0;
    if (state_r == WRITE) begin
      for (int unsigned p = 0; p < TcdmPorts; p++) begin
        widx = int'(beat_r) * TcdmPorts + p;
        tcdm_q_addr_o[p*AddrWidth +: AddrWidth] = base_r + AddrWidth'(widx * StrbW);
        tcdm_q_data_o[p*DataWidth +: DataWidth] = tile_r[widx*DataWidth +: DataWidth];
      end
    end else begin
      tcdm_q_addr_o = '0;
      tcdm_q_data_o = '0;
    end
  end

  assign tcdm_q_valid_o = q_valid_s;
  assign tcdm_q_write_o = |q_valid_s;
  assign tcdm_q_strb_o  = (|q_valid_s) ? {StrbW{1'b1}} : {StrbW{1'b0}};
  assign c_ready_o      = (state_r == IDLE);
  assign busy_o         = (state_r == WRITE) || (state_r == DONE);
  assign done_o         = (state_r == DONE);

`ifdef SNAX_GEMM_WB_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of WRITE cycles where some valid port is held off
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
    end else if (capture_s) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == WRITE) && (|(q_valid_s & ~tcdm_q_ready_i))
                 && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule
